// File: rtl/ex_pipe.sv
// Three-stage pipelined e^x approximation with valid/ready flow control.
// Range reduction to n*ln2 + r, polynomial e^r, 2^n scaling with clamp and saturation count.
module ex_pipe #(
    parameter int IN_W     = 8,
    parameter int IN_FRAC  = 6,
    parameter int OUT_W    = 9,
    parameter int OUT_FRAC = 6,
    parameter int ORDER    = 1,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_x,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_e,
    output logic               out_last,
    output logic               out_sat,
    output logic [CNT_W-1:0]   sat_cnt,
    input  logic               sat_clr
);
    localparam real LN2_R  = 0.6931471805599453;
    localparam real ONE_R  = real'(2 ** IN_FRAC);
    localparam int  INVLN2 = int'(ONE_R / LN2_R);
    localparam int  LN2    = int'(ONE_R * LN2_R);
    localparam int  PW     = IN_W + 16;
    localparam int  RW     = IN_W + 4;
    localparam int  EW     = IN_W + 6;
    localparam int  YW     = IN_W + OUT_W + 8;

    localparam logic signed [PW-1:0] INVLN2_P = PW'(INVLN2);
    localparam logic signed [PW-1:0] LN2_P    = PW'(LN2);
    localparam logic signed [PW-1:0] H_P      = PW'(2 ** (IN_FRAC - 1));
    localparam logic signed [EW-1:0] ONE_E    = EW'(2 ** IN_FRAC);
    localparam logic signed [YW-1:0] S_OFS    = YW'(OUT_FRAC - IN_FRAC);

    logic              v1_reg, v2_reg, v3_reg;
    logic signed [7:0] n1_reg, n2_reg;
    logic signed [RW-1:0] r1_reg;
    logic signed [EW-1:0] e2_reg;
    logic              last1_reg, last2_reg, last3_reg;
    logic [OUT_W-1:0]  e3_reg;
    logic              sat3_reg;
    logic [CNT_W-1:0]  sat_cnt_reg;

    logic rdy1, rdy2, rdy3;
    assign rdy3     = !v3_reg | out_ready;
    assign rdy2     = !v2_reg | rdy3;
    assign rdy1     = !v1_reg | rdy2;
    assign in_ready = rdy1;

    // S1: n = round-ish(x/ln2) via fixed-point reciprocal, r = x - n*ln2
    logic signed [PW-1:0] x_ext, p_s1, n_ext;
    logic signed [7:0]    n_next;
    logic signed [RW-1:0] r_next;
    always_comb begin
        x_ext  = PW'($signed(in_x));
        p_s1   = (x_ext * INVLN2_P) >>> IN_FRAC;
        n_next = 8'((p_s1 + (p_s1[PW-1] ? -H_P : H_P)) >>> IN_FRAC);
        n_ext  = PW'(n_next);
        r_next = RW'(x_ext - n_ext * LN2_P);
    end

    // S2: e^r polynomial; ORDER values other than 2 build the linear form
    logic signed [EW-1:0] e_lin, e_next;
    assign e_lin = EW'(r1_reg) + ONE_E;
    generate
        if (ORDER == 2) begin : g_ord2
            logic signed [2*RW-1:0] r_wide;
            assign r_wide = (2*RW)'(r1_reg);
            assign e_next = e_lin + EW'((r_wide * r_wide) >>> (IN_FRAC + 1));
        end else begin : g_ord1
            assign e_next = e_lin;
        end
    endgenerate

    // S3: scale by 2^s in a wide signed domain, then clamp into OUT_W
    logic signed [YW-1:0] e_y, s_y, y_s3;
    logic                 under_s3, over_s3;
    logic [OUT_W-1:0]     e_s3;
    always_comb begin
        e_y      = YW'(e2_reg);
        s_y      = YW'(n2_reg) + S_OFS;
        y_s3     = s_y[YW-1] ? (e_y >>> (-s_y)) : (e_y <<< s_y);
        under_s3 = y_s3[YW-1];
        over_s3  = !y_s3[YW-1] && (|y_s3[YW-2:OUT_W]);
        e_s3     = y_s3[OUT_W-1:0];
        if (under_s3) e_s3 = '0;
        else if (over_s3) e_s3 = '1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_reg      <= 1'b0;
            v2_reg      <= 1'b0;
            v3_reg      <= 1'b0;
            n1_reg      <= '0;
            r1_reg      <= '0;
            last1_reg   <= 1'b0;
            n2_reg      <= '0;
            e2_reg      <= '0;
            last2_reg   <= 1'b0;
            e3_reg      <= '0;
            last3_reg   <= 1'b0;
            sat3_reg    <= 1'b0;
            sat_cnt_reg <= '0;
        end else begin
            if (rdy1) begin
                v1_reg <= in_valid;
                if (in_valid) begin
                    n1_reg    <= n_next;
                    r1_reg    <= r_next;
                    last1_reg <= in_last;
                end
            end
            if (rdy2) begin
                v2_reg <= v1_reg;
                if (v1_reg) begin
                    n2_reg    <= n1_reg;
                    e2_reg    <= e_next;
                    last2_reg <= last1_reg;
                end
            end
            if (rdy3) begin
                v3_reg <= v2_reg;
                if (v2_reg) begin
                    e3_reg    <= e_s3;
                    last3_reg <= last2_reg;
                    sat3_reg  <= under_s3 | over_s3;
                end
            end
            // clear wins over a same-cycle increment
            if (sat_clr)
                sat_cnt_reg <= '0;
            else if (v3_reg && out_ready && sat3_reg && !(&sat_cnt_reg))
                sat_cnt_reg <= sat_cnt_reg + 1'b1;
        end
    end

    assign out_valid = v3_reg;
    assign out_e     = e3_reg;
    assign out_last  = last3_reg;
    assign out_sat   = sat3_reg;
    assign sat_cnt   = sat_cnt_reg;
endmodule

// File: tb/tb_ex_pipe.sv
// Directed and randomized-handshake bench for ex_pipe across three parameter sets:
// default, second-order polynomial, and 8-bit output with saturation.
module tb_ex_pipe;
    logic clk = 1'b0;
    logic rst, in_valid, in_last, out_ready, sat_clr;
    logic [7:0] in_x;

    logic a_in_ready, a_out_valid, a_out_last, a_out_sat;
    logic [8:0] a_out_e;
    logic [15:0] a_sat_cnt;
    logic b_in_ready, b_out_valid, b_out_last, b_out_sat;
    logic [8:0] b_out_e;
    logic [15:0] b_sat_cnt;
    logic c_in_ready, c_out_valid, c_out_last, c_out_sat;
    logic [7:0] c_out_e;
    logic [15:0] c_sat_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_pipe u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_x(in_x),
        .in_last(in_last), .out_valid(a_out_valid), .out_ready(out_ready), .out_e(a_out_e),
        .out_last(a_out_last), .out_sat(a_out_sat), .sat_cnt(a_sat_cnt), .sat_clr(sat_clr)
    );
    ex_pipe #(.ORDER(2)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_x(in_x),
        .in_last(in_last), .out_valid(b_out_valid), .out_ready(out_ready), .out_e(b_out_e),
        .out_last(b_out_last), .out_sat(b_out_sat), .sat_cnt(b_sat_cnt), .sat_clr(sat_clr)
    );
    ex_pipe #(.OUT_W(8)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready), .in_x(in_x),
        .in_last(in_last), .out_valid(c_out_valid), .out_ready(out_ready), .out_e(c_out_e),
        .out_last(c_out_last), .out_sat(c_out_sat), .sat_cnt(c_sat_cnt), .sat_clr(sat_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference e^x for the default Q1.6 input format
    function automatic int model(input int x, input int order, input int outw, output int sat);
        int p, n, r, e, y, mx;
        p = (x * 92) >>> 6;
        n = (p + ((p < 0) ? -32 : 32)) >>> 6;
        r = x - n * 44;
        e = 64 + r;
        if (order == 2) e = e + ((r * r) >>> 7);
        y = (n >= 0) ? (e <<< n) : (e >>> (-n));
        mx = (1 << outw) - 1;
        sat = 0;
        if (y < 0) begin sat = 1; y = 0; end
        else if (y > mx) begin sat = 1; y = mx; end
        return y;
    endfunction

    int vx[4] = '{0, 64, -128, 127};
    int ea[4] = '{64, 168, 7, 472};
    int eb[4] = '{64, 174, 8, 472};
    int ec[4] = '{64, 168, 7, 255};
    int sc[4] = '{0, 0, 0, 1};
    int bx[5] = '{0, 64, -128, 127, 0};
    int be[5] = '{64, 168, 7, 472, 64};
    int bl[5] = '{0, 1, 0, 0, 1};

    int qx[$];
    int ql[$];

    initial begin
        int idx, oidx, sent, recv, cyc, x, l, s, ev, stale;
        bit pend;
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; sat_clr = 1'b0; in_x = '0;
        step(); step();
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_e", a_out_e, 0);
        chk("rst_out_last", a_out_last, 0);
        chk("rst_out_sat", a_out_sat, 0);
        chk("rst_sat_cnt", c_sat_cnt, 0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", a_in_ready, 1);

        // Single beats: latency and known results
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_x = vx[i][7:0]; in_last = i[0]; out_ready = 1'b1;
            #1;
            chk("single_in_ready", a_in_ready, 1);
            step();
            in_valid = 1'b0;
            step();
            chk("single_early_valid", a_out_valid, 0);
            step();
            chk("single_out_valid", a_out_valid, 1);
            chk("single_a_e", a_out_e, ea[i]);
            chk("single_b_e", b_out_e, eb[i]);
            chk("single_c_e", c_out_e, ec[i]);
            chk("single_c_sat", c_out_sat, sc[i]);
            chk("single_a_sat", a_out_sat, 0);
            chk("single_last", a_out_last, i[0]);
            step();
        end
        chk("sat_cnt_one", c_sat_cnt, 1);

        // Clear and increment in the same cycle: clear wins
        in_valid = 1'b1; in_x = 8'd127;
        step();
        in_valid = 1'b0;
        step(); step();
        chk("clr_pre_sat", c_out_sat, 1);
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        chk("clr_priority", c_sat_cnt, 0);

        // Backpressure: stalled output accepts exactly three beats
        out_ready = 1'b0; idx = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_x = bx[idx][7:0]; in_last = bl[idx][0];
            #1;
            if (a_in_ready) idx++;
            step();
        end
        #1;
        chk("bp_accepted", idx, 3);
        chk("bp_in_ready", a_in_ready, 0);
        out_ready = 1'b1; oidx = 0; cyc = 0;
        while (oidx < 5 && cyc < 40) begin
            in_valid = (idx < 5); in_x = bx[idx < 5 ? idx : 0][7:0]; in_last = bl[idx < 5 ? idx : 0][0];
            #1;
            if (in_valid && a_in_ready) idx++;
            if (a_out_valid) begin
                chk("bp_out_e", a_out_e, be[oidx]);
                chk("bp_out_last", a_out_last, bl[oidx]);
                oidx++;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        chk("bp_out_count", oidx, 5);

        // Random valid/ready over 1000 beats against the model
        sent = 0; recv = 0; cyc = 0; pend = 0;
        while (recv < 1000 && cyc < 20000) begin
            if (!pend) begin
                if (sent < 1000 && $urandom_range(0, 9) < 7) begin
                    in_x = 8'($urandom_range(0, 255));
                    in_last = 1'($urandom_range(0, 1));
                    in_valid = 1'b1;
                    pend = 1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            if (in_valid && a_in_ready) begin
                qx.push_back(int'($signed(in_x)));
                ql.push_back(int'(in_last));
                sent++;
                pend = 0;
            end
            if (a_out_valid && out_ready) begin
                chk("rand_queue_nonempty", qx.size() > 0, 1);
                if (qx.size() > 0) begin
                    x = qx.pop_front();
                    l = ql.pop_front();
                    ev = model(x, 1, 9, s);
                    chk("rand_a", {a_out_sat, a_out_last, a_out_e}, (s << 10) | (l << 9) | ev);
                    ev = model(x, 2, 9, s);
                    chk("rand_b", {b_out_sat, b_out_last, b_out_e}, (s << 10) | (l << 9) | ev);
                    ev = model(x, 1, 8, s);
                    chk("rand_c", {c_out_sat, c_out_last, c_out_e}, (s << 9) | (l << 8) | ev);
                end
                recv++;
            end
            step();
            cyc++;
        end
        chk("rand_recv", recv, 1000);

        // Reset with all three stages occupied
        in_valid = 1'b1; in_x = 8'd127; in_last = 1'b1; out_ready = 1'b0;
        step(); step(); step(); step();
        chk("full_out_valid", a_out_valid, 1);
        chk("full_in_ready", a_in_ready, 0);
        chk("full_sat_cnt_nonzero", c_sat_cnt != 0, 1);
        rst = 1'b1;
        step();
        chk("midrst_out_valid", a_out_valid, 0);
        chk("midrst_sat_cnt", c_sat_cnt, 0);
        chk("midrst_in_ready", a_in_ready, 1);
        chk("midrst_out_e", a_out_e, 0);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (a_out_valid || c_out_valid) stale++;
        end
        chk("no_stale_beat", stale, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
